// File: rtl/mul_norm_pkg.sv
// Shared constants, types and helpers for the shared leading-one normalizer in mul_para.
package mul_norm_pkg;

  localparam int NREQ = 2;

  function automatic int lzc_w(input int width);
    return $clog2(width);
  endfunction

  localparam int NORM_WIDTH = 24;
  localparam int NORM_TAG_W = 4;
  localparam int NORM_AW    = lzc_w(NORM_WIDTH);

  typedef struct packed {
    logic [NORM_WIDTH-1:0] mant;
    logic [NORM_TAG_W-1:0] tag;
    logic                  src;
  } norm_req_t;

  typedef struct packed {
    logic [NORM_WIDTH-1:0] mant;
    logic [NORM_AW-1:0]    lzc;
    logic                  zero;
    logic [NORM_TAG_W-1:0] tag;
    logic                  src;
  } norm_rsp_t;

endpackage

// File: rtl/mul_norm_arb_if.sv
// Two-lane mantissa request bus plus the single normalized result stream.
interface mul_norm_arb_if
  import mul_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
);
  localparam int AW = lzc_w(WIDTH);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_mant;
  logic [NREQ-1:0][TAG_W-1:0] req_tag;

  logic                       out_valid;
  logic                       out_ready;
  logic                       out_src;
  logic [TAG_W-1:0]           out_tag;
  logic [WIDTH-1:0]           out_mant;
  logic [AW-1:0]              out_lzc;
  logic                       out_zero;

  modport master (
    output req_valid, req_mant, req_tag, out_ready,
    input  req_ready, out_valid, out_src, out_tag, out_mant, out_lzc, out_zero
  );

  modport slave (
    input  req_valid, req_mant, req_tag, out_ready,
    output req_ready, out_valid, out_src, out_tag, out_mant, out_lzc, out_zero
  );
endinterface

// File: rtl/mul_lod.sv
// Leading-one detector: left-aligns the input into 32 bits and resolves the zero count
// with fixed 16/8/4/2/1 halving stages. Count is meaningless when o_zero is set.
module mul_lod
  import mul_norm_pkg::*;
#(
  parameter int INPUT_WIDTH = 24
) (
  input  logic [INPUT_WIDTH-1:0] i_data,
  output logic [4:0]             o_lzc,
  output logic                   o_zero
);
  logic [31:0] w_s0;
  logic [15:0] w_s1;
  logic [7:0]  w_s2;
  logic [3:0]  w_s3;
  logic [1:0]  w_s4;
  logic [4:0]  w_cnt;

  // Zero padding goes below the LSB so counts are measured from the real MSB.
  assign w_s0     = 32'(i_data) << (32 - INPUT_WIDTH);
  assign w_cnt[4] = ~|w_s0[31:16];
  assign w_s1     = w_cnt[4] ? w_s0[15:0] : w_s0[31:16];
  assign w_cnt[3] = ~|w_s1[15:8];
  assign w_s2     = w_cnt[3] ? w_s1[7:0] : w_s1[15:8];
  assign w_cnt[2] = ~|w_s2[7:4];
  assign w_s3     = w_cnt[2] ? w_s2[3:0] : w_s2[7:4];
  assign w_cnt[1] = ~|w_s3[3:2];
  assign w_s4     = w_cnt[1] ? w_s3[1:0] : w_s3[3:2];
  assign w_cnt[0] = ~w_s4[1] & w_s4[0];

  assign o_lzc  = w_cnt;
  assign o_zero = ~|i_data;
endmodule

// File: rtl/mul_norm_arb.sv
// Round-robin arbiter in front of a 2-stage normalizer shared by the two multiplier lanes:
// S1 registers the granted request, S2 detects the leading one, shifts and registers the result.
module mul_norm_arb
  import mul_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_norm_arb_if.slave  bus
);
  localparam int AW = lzc_w(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [TAG_W-1:0] tag;
    logic             src;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] mant;
    logic [AW-1:0]    lzc;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic             src;
  } rsp_t;

  if (WIDTH < 17 || WIDTH > 32) begin : g_bad_width
    $error("mul_norm_arb: WIDTH must lie in 17..32");
  end

  logic            r_s1_valid;
  req_t            r_s1;
  logic            r_out_valid;
  rsp_t            r_out;
  logic            r_rr_last;

  logic            w_s2_ready;
  logic            w_s1_ready;
  logic [NREQ-1:0] w_grant;
  logic            w_sel;
  logic            w_accept;
  req_t            w_req;
  logic [AW-1:0]   w_lzc;
  logic            w_zero;
  logic [WIDTH-1:0] w_shifted;

  assign w_s2_ready = !r_out_valid || bus.out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;

  // On a tie the lane not served last wins; r_rr_last=1 after reset favours lane 0.
  assign w_grant[0]    = bus.req_valid[0] & (~bus.req_valid[1] | r_rr_last);
  assign w_grant[1]    = bus.req_valid[1] & (~bus.req_valid[0] | ~r_rr_last);
  assign bus.req_ready = w_grant & {NREQ{w_s1_ready & rst_n}};
  assign w_accept      = |(bus.req_valid & bus.req_ready);
  assign w_sel         = w_grant[1];
  assign w_req         = '{mant: bus.req_mant[w_sel], tag: bus.req_tag[w_sel], src: w_sel};

  mul_lod #(
    .INPUT_WIDTH(WIDTH)
  ) u_lod (
    .i_data (r_s1.mant),
    .o_lzc  (w_lzc),
    .o_zero (w_zero)
  );

  assign w_shifted = r_s1.mant << w_lzc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_rr_last   <= 1'b1;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1      <= w_req;
          r_rr_last <= w_sel;
        end
      end
      if (w_s2_ready) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out.mant <= w_zero ? '0 : w_shifted;
          r_out.lzc  <= w_zero ? '0 : w_lzc;
          r_out.zero <= w_zero;
          r_out.tag  <= r_s1.tag;
          r_out.src  <= r_s1.src;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_src   = r_out.src;
  assign bus.out_tag   = r_out.tag;
  assign bus.out_mant  = r_out.mant;
  assign bus.out_lzc   = r_out.lzc;
  assign bus.out_zero  = r_out.zero;
endmodule
